lsu_ctrl: RTL and testbench

Load/store controller that initiates all data-memory accesses on behalf of the core's MEM stage and drives the data memory port. It accepts one load/store request at a time from the pipeline and checks its size, alignment and bounds. It then issues either one aligned access or a byte-serial sequence for misaligned accesses, and returns a registered response with assembled, sign- or zero-extended load data and an error flag.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_load_ext.sv | 28 ++
 rtl/lsu_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller.
// States, access-size encodings and a byte-count helper used by
// lsu_ctrl and lsu_load_ext.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Number of bytes covered by an access of the given size. The illegal
    // encoding reports one byte so the bounds arithmetic stays well defined;
    // such requests are rejected separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result extension: takes right-aligned assembled load data and
// sign- or zero-extends it according to the access size.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        unsigned_ext,
    output logic [31:0] result
);

    logic sign_b;
    logic sign_h;

    assign sign_b = data[7]  & ~unsigned_ext;
    assign sign_h = data[15] & ~unsigned_ext;

    // Replicate the sign bit (or zero) above the loaded field.
    always_comb begin
        result = data;
        case (size)
            SZ_B:    result = {{24{sign_b}}, data[7:0]};
            SZ_H:    result = {{16{sign_h}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for the MEM stage. Accepts one request at a time,
// classifies it (size, bounds, alignment), performs one aligned memory
// cycle or a byte-serial sequence, and returns a registered response.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// half/word requests are split into byte accesses; otherwise they fault.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataW,
    output logic        mem_MemRW,
    output logic [1:0]  mem_MemSize,
    output logic        mem_MemUnsigned,
    input  logic [31:0] mem_dataR
);

    lsu_state_e  state;
    lsu_state_e  state_next;

    logic        accept;
    logic [2:0]  nbytes_in;
    logic [32:0] last_byte;
    logic        bad_size;
    logic        out_of_range;
    logic        misaligned;
    logic        req_err;

    // Request fields held for the duration of the access.
    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] ext_in;
    logic [31:0] ext_out;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  k_q;
    logic [31:0] asm_q;
    logic [31:0] wdata_shift;
    logic        split_last;
`endif

    assign req_ready = (state == IDLE) || (state == RESP);
    assign accept    = req_valid && req_ready;

    // Classify the incoming request; the end address is formed in 33 bits
    // so a request near the top of the address space cannot wrap to zero.
    always_comb begin
        nbytes_in    = size_bytes(req_size);
        last_byte    = {1'b0, req_addr} + {30'b0, nbytes_in} - 33'd1;
        bad_size     = (req_size == 2'b11);
        out_of_range = (last_byte >= 33'(DEPTH_BYTES));
        misaligned   = ((req_size == SZ_H) && req_addr[0]) ||
                       ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
        req_err      = bad_size || out_of_range;
`else
        req_err      = bad_size || out_of_range || misaligned;
`endif
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. Acceptance is allowed in RESP so aligned requests
    // can issue every other cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                    end else if (misaligned) begin
                        state_next = SPLIT;
`endif
                    end else begin
                        state_next = ACCESS;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                if (split_last) begin
                    state_next = RESP;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request on handshake; pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    assign split_last  = (k_q == ((size_q == SZ_H) ? 2'd1 : 2'd3));
    assign wdata_shift = wdata_q >> {k_q, 3'b000};

    // Byte index within a split sequence; restarts at zero outside SPLIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= 2'd0;
        end else if (state == SPLIT) begin
            k_q <= k_q + 2'd1;
        end else begin
            k_q <= 2'd0;
        end
    end

    // Accumulate load bytes of a split sequence, little-endian.
    always_ff @(posedge clk) begin
        if (accept) begin
            asm_q <= '0;
        end else if (state == SPLIT) begin
            asm_q <= ext_in;
        end
    end
`endif

    // Raw load value feeding the extender: the memory word for an aligned
    // access, or the partial assembly merged with the current byte.
    always_comb begin
        ext_in = mem_dataR;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state == SPLIT) begin
            ext_in = asm_q | (32'({24'b0, mem_dataR[7:0]}) << {k_q, 3'b000});
        end
`endif
    end

    lsu_load_ext u_load_ext (
        .data         (ext_in),
        .size         (size_q),
        .unsigned_ext (unsigned_q),
        .result       (ext_out)
    );

    // Response register: loaded on entry to RESP. Entering from IDLE/RESP
    // can only mean a faulted request, which never touched memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= (state_next == RESP);
            if ((state_next == RESP) && req_ready) begin
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end else if ((state_next == RESP) && !we_q) begin
                resp_err   <= 1'b0;
                resp_rdata <= ext_out;
            end else begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    // Memory port decoded from state so the write enable drops the moment
    // reset asserts; idle states drive a quiet bus.
    always_comb begin
        mem_addr        = '0;
        mem_dataW       = '0;
        mem_MemRW       = 1'b0;
        mem_MemSize     = SZ_B;
        mem_MemUnsigned = 1'b1;
        case (state)
            ACCESS: begin
                mem_addr    = addr_q;
                mem_dataW   = wdata_q;
                mem_MemRW   = we_q;
                mem_MemSize = size_q;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                mem_addr    = addr_q + {30'b0, k_q};
                mem_dataW   = {24'b0, wdata_shift[7:0]};
                mem_MemRW   = we_q;
                mem_MemSize = SZ_B;
            end
`endif
            default: begin
                mem_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: behavioural byte memory on the memory port, plus
// a request-level reference model (byte array + size/bounds/alignment rules).
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          wr;
        logic        bad_sz;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_dataW;
    logic        mem_MemRW;
    logic [1:0]  mem_MemSize;
    logic        mem_MemUnsigned;
    logic [31:0] mem_dataR;

    int checks   = 0;
    int failures = 0;

    logic        mem_clear;
    logic [7:0]  phys [DEPTH];
    logic [7:0]  refm [DEPTH];
    int          mem_nb;
    logic [31:0] wr_addrs [$];

    lsu_ctrl #(.DEPTH_BYTES(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_addr        (mem_addr),
        .mem_dataW       (mem_dataW),
        .mem_MemRW       (mem_MemRW),
        .mem_MemSize     (mem_MemSize),
        .mem_MemUnsigned (mem_MemUnsigned),
        .mem_dataR       (mem_dataR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge.
    always_comb mem_nb = (mem_MemSize == 2'b00) ? 1 : (mem_MemSize == 2'b01) ? 2 : 4;

    always_comb begin
        mem_dataR = '0;
        for (int i = 0; i < 4; i++)
            if (i < mem_nb && (longint'(mem_addr) + i) < DEPTH)
                mem_dataR[8*i +: 8] = phys[AW'(mem_addr + 32'(i))];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) phys[i] <= 8'h00;
        end else if (mem_MemRW) begin
            for (int i = 0; i < 4; i++)
                if (i < mem_nb && (longint'(mem_addr) + i) < DEPTH)
                    phys[AW'(mem_addr + 32'(i))] <= mem_dataW[8*i +: 8];
        end
    end

    // Reference model: expected outcome of one request; updates refm on stores.
    task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, output obs_t e);
        int nb;
        longint last;
        bit mis;
        logic [31:0] v;
        nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        last = longint'(addr) + nb - 1;
        mis  = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        e.bad_sz = 1'b0;
        e.err    = (size == 2'b11) || (last >= DEPTH) || (mis && !SPLIT_EN);
        if (e.err) begin
            e.lat = 1; e.rdata = 0; e.wr = 0;
        end else begin
            e.lat = mis ? nb + 1 : 2;
            e.wr  = we ? (mis ? nb : 1) : 0;
            if (we) begin
                for (int i = 0; i < nb; i++) refm[AW'(addr + 32'(i))] = wdata[8*i +: 8];
                e.rdata = 0;
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = refm[AW'(addr + 32'(i))];
                if (size == 2'b00 && !uns && v[7])  v = v | 32'hFFFF_FF00;
                if (size == 2'b01 && !uns && v[15]) v = v | 32'hFFFF_0000;
                e.rdata = v;
            end
        end
    endtask

    // Drive one request and observe it until the response (bounded).
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output obs_t o, output obs_t e);
        model_req(we, size, uns, addr, wdata, e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int w = 0; w < 8 && !req_ready; w++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        o.lat = -1; o.err = 1'b0; o.rdata = '0; o.wr = 0; o.bad_sz = 1'b0;
        wr_addrs.delete();
        for (int n = 1; n <= 12; n++) begin
            if (mem_MemSize === 2'b11) o.bad_sz = 1'b1;
            if (mem_MemRW === 1'b1) begin
                o.wr++;
                wr_addrs.push_back(mem_addr);
            end
            if (resp_valid === 1'b1) begin
                o.lat = n; o.err = resp_err; o.rdata = resp_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_clear = 1'b1; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (mem_MemRW !== 1'b0) begin failures++; $display("FAIL reset_memrw got %b want 0", mem_MemRW); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_dataW !== 32'h0) begin failures++; $display("FAIL reset_mem_dataW got %h want 0", mem_dataW); end
        checks++; if (mem_MemSize !== 2'b00) begin failures++; $display("FAIL reset_mem_size got %b want 00", mem_MemSize); end
        checks++; if (mem_MemUnsigned !== 1'b1) begin failures++; $display("FAIL reset_mem_unsigned got %b want 1", mem_MemUnsigned); end
        mem_clear = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_aligned();
        obs_t o, e;
        run_req(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, o, e);
        checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL sw_err got %b want 0", o.err); end
        checks++; if (o.lat != 2) begin failures++; $display("FAIL sw_latency got %0d want 2", o.lat); end
        checks++; if (o.wr != 1) begin failures++; $display("FAIL sw_memrw_cycles got %0d want 1", o.wr); end
        run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, o, e);
        checks++; if (o.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got %h want deadbeef", o.rdata); end
        checks++; if (o.lat != 2 || o.err !== 1'b0) begin failures++; $display("FAIL lw_lat_err got %0d/%b want 2/0", o.lat, o.err); end
        checks++; if (o.wr != 0) begin failures++; $display("FAIL lw_memrw_cycles got %0d want 0", o.wr); end
    endtask

    task automatic test_signed_bytes();
        obs_t o, e;
        run_req(1'b1, SZ_B, 1'b0, 32'h21, 32'h1234_5680, o, e);
        checks++; if (phys[AW'(32'h21)] !== 8'h80 || phys[AW'(32'h22)] !== 8'h00) begin failures++; $display("FAIL sb_bytes got %h %h want 80 00", phys[AW'(32'h21)], phys[AW'(32'h22)]); end
        run_req(1'b0, SZ_B, 1'b0, 32'h21, 32'h0, o, e);
        checks++; if (o.rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got %h want ffffff80", o.rdata); end
        run_req(1'b0, SZ_B, 1'b1, 32'h21, 32'h0, o, e);
        checks++; if (o.rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_rdata got %h want 00000080", o.rdata); end
        run_req(1'b0, SZ_H, 1'b0, 32'h20, 32'h0, o, e);
        checks++; if (o.rdata !== 32'hFFFF_8000) begin failures++; $display("FAIL lh_rdata got %h want ffff8000", o.rdata); end
        run_req(1'b0, SZ_H, 1'b1, 32'h20, 32'h0, o, e);
        checks++; if (o.rdata !== 32'h0000_8000) begin failures++; $display("FAIL lhu_rdata got %h want 00008000", o.rdata); end
    endtask

    task automatic test_misaligned();
        obs_t o, e;
        logic [31:0] a;
`ifdef LSU_MISALIGN_SPLIT_EN
        run_req(1'b1, SZ_W, 1'b0, 32'h13, 32'h1122_3344, o, e);
        checks++; if (o.lat != 5 || o.err !== 1'b0) begin failures++; $display("FAIL split_sw_lat_err got %0d/%b want 5/0", o.lat, o.err); end
        checks++; if (o.wr != 4) begin failures++; $display("FAIL split_sw_writes got %0d want 4", o.wr); end
        for (int i = 0; i < 4; i++) begin
            a = (i < wr_addrs.size()) ? wr_addrs[i] : 32'hFFFF_FFFF;
            checks++; if (a !== 32'h13 + 32'(i)) begin failures++; $display("FAIL split_sw_addr%0d got %h want %h", i, a, 32'h13 + 32'(i)); end
        end
        run_req(1'b0, SZ_W, 1'b0, 32'h13, 32'h0, o, e);
        checks++; if (o.rdata !== 32'h1122_3344 || o.lat != 5) begin failures++; $display("FAIL split_lw got %h lat %0d want 11223344 lat 5", o.rdata, o.lat); end
        run_req(1'b1, SZ_H, 1'b0, 32'h31, 32'h0000_8123, o, e);
        checks++; if (o.lat != 3 || o.wr != 2) begin failures++; $display("FAIL split_sh got lat %0d wr %0d want 3 2", o.lat, o.wr); end
        run_req(1'b0, SZ_H, 1'b0, 32'h31, 32'h0, o, e);
        checks++; if (o.rdata !== 32'hFFFF_8123) begin failures++; $display("FAIL split_lh got %h want ffff8123", o.rdata); end
        run_req(1'b0, SZ_H, 1'b1, 32'h31, 32'h0, o, e);
        checks++; if (o.rdata !== 32'h0000_8123) begin failures++; $display("FAIL split_lhu got %h want 00008123", o.rdata); end
`else
        run_req(1'b0, SZ_H, 1'b0, 32'h31, 32'h0, o, e);
        checks++; if (o.err !== 1'b1 || o.lat != 1) begin failures++; $display("FAIL mis_lh got err %b lat %0d want 1 1", o.err, o.lat); end
        checks++; if (o.rdata !== 32'h0 || o.wr != 0) begin failures++; $display("FAIL mis_lh_data got %h wr %0d want 0 0", o.rdata, o.wr); end
        run_req(1'b1, SZ_W, 1'b0, 32'h13, 32'h1122_3344, o, e);
        checks++; if (o.err !== 1'b1 || o.wr != 0) begin failures++; $display("FAIL mis_sw got err %b wr %0d want 1 0", o.err, o.wr); end
        run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, o, e);
        checks++; if (o.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mis_sw_untouched got %h want deadbeef", o.rdata); end
`endif
    endtask

    task automatic test_bounds_illegal();
        obs_t o, e;
        run_req(1'b0, SZ_W, 1'b0, 32'(DEPTH - 2), 32'h0, o, e);
        checks++; if (o.err !== 1'b1 || o.lat != 1 || o.rdata !== 32'h0 || o.wr != 0) begin failures++; $display("FAIL oob_lw got err %b lat %0d rd %h wr %0d", o.err, o.lat, o.rdata, o.wr); end
        run_req(1'b0, SZ_W, 1'b0, 32'(DEPTH - 4), 32'h0, o, e);
        checks++; if (o.err !== 1'b0 || o.lat != 2 || o.rdata !== e.rdata) begin failures++; $display("FAIL top_lw got err %b lat %0d rd %h want 0 2 %h", o.err, o.lat, o.rdata, e.rdata); end
        run_req(1'b1, SZ_B, 1'b0, 32'(DEPTH - 1), 32'h0000_005A, o, e);
        checks++; if (o.err !== 1'b0 || o.wr != 1) begin failures++; $display("FAIL top_sb got err %b wr %0d want 0 1", o.err, o.wr); end
        run_req(1'b0, SZ_B, 1'b1, 32'(DEPTH - 1), 32'h0, o, e);
        checks++; if (o.rdata !== 32'h5A) begin failures++; $display("FAIL top_lbu got %h want 5a", o.rdata); end
        run_req(1'b0, SZ_W, 1'b0, 32'hFFFF_FFFC, 32'h0, o, e);
        checks++; if (o.err !== 1'b1) begin failures++; $display("FAIL wrap_lw got err %b want 1", o.err); end
        run_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, o, e);
        checks++; if (o.err !== 1'b1 || o.lat != 1 || o.rdata !== 32'h0) begin failures++; $display("FAIL sz11_load got err %b lat %0d rd %h", o.err, o.lat, o.rdata); end
        checks++; if (o.bad_sz !== 1'b0) begin failures++; $display("FAIL sz11_load_memsize got 11 on bus want never"); end
        run_req(1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFF_FFFF, o, e);
        checks++; if (o.err !== 1'b1 || o.wr != 0 || o.bad_sz !== 1'b0) begin failures++; $display("FAIL sz11_store got err %b wr %0d badsz %b", o.err, o.wr, o.bad_sz); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        run_req(1'b1, SZ_W, 1'b0, 32'h50, 32'hCAFE_F00D, o, e);
        run_req(1'b1, SZ_W, 1'b0, 32'h54, 32'h0123_4567, o, e);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0; req_addr = 32'h50;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h54;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy_ready got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_first got v %b rd %h want 1 cafef00d", resp_valid, resp_rdata); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_resp_ready got %b want 1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || mem_addr !== 32'h54) begin failures++; $display("FAIL b2b_second_access got v %b addr %h want 0 54", resp_valid, mem_addr); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0123_4567) begin failures++; $display("FAIL b2b_second got v %b rd %h want 1 01234567", resp_valid, resp_rdata); end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic we, uns;
        logic [1:0] size;
        logic [31:0] addr, wdata;
        int sel;
        bit bad;
        for (int it = 0; it < 60; it++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sel   = int'($urandom_range(0, 9));
            addr  = (sel == 0) ? 32'(DEPTH) - 32'($urandom_range(1, 4)) :
                    (sel == 1) ? $urandom : 32'h100 + 32'($urandom_range(0, 63));
            wdata = $urandom;
            run_req(we, size, uns, addr, wdata, o, e);
            checks++; if (o.err !== e.err || o.lat != e.lat) begin failures++; $display("FAIL rand%0d_err_lat got %b/%0d want %b/%0d", it, o.err, o.lat, e.err, e.lat); end
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL rand%0d_rdata got %h want %h", it, o.rdata, e.rdata); end
            checks++; if (o.wr != e.wr || o.bad_sz !== 1'b0) begin failures++; $display("FAIL rand%0d_writes got %0d badsz %b want %0d 0", it, o.wr, o.bad_sz, e.wr); end
            bad = 1'b0;
            for (int i = 0; i < 4; i++)
                if ((longint'(addr) + i) < DEPTH && phys[AW'(addr + 32'(i))] !== refm[AW'(addr + 32'(i))]) bad = 1'b1;
            checks++; if (bad) begin failures++; $display("FAIL rand%0d_memory got differing bytes near %h want model contents", it, addr); end
        end
    endtask

    task automatic test_reset_split();
        obs_t o, e;
        bit saw_valid;
        @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 32'h41; req_wdata = 32'hA1B2_C3D4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
`else
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 32'h60; req_wdata = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        checks++; if (mem_MemRW !== 1'b0) begin failures++; $display("FAIL rst_abort_memrw got %b want 0", mem_MemRW); end
        checks++; if (req_ready !== 1'b1 || mem_addr !== 32'h0) begin failures++; $display("FAIL rst_abort_idle got ready %b addr %h want 1 0", req_ready, mem_addr); end
        saw_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) saw_valid = 1'b1;
            if (n == 2) rst_n = 1'b1;
        end
        checks++; if (saw_valid) begin failures++; $display("FAIL rst_abort_resp got resp_valid 1 want 0"); end
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (phys[AW'(32'h41)] !== 8'hD4 || phys[AW'(32'h42)] !== 8'hC3) begin failures++; $display("FAIL rst_abort_written got %h %h want d4 c3", phys[AW'(32'h41)], phys[AW'(32'h42)]); end
        checks++; if (phys[AW'(32'h43)] !== refm[AW'(32'h43)] || phys[AW'(32'h44)] !== refm[AW'(32'h44)]) begin failures++; $display("FAIL rst_abort_unwritten got %h %h want %h %h", phys[AW'(32'h43)], phys[AW'(32'h44)], refm[AW'(32'h43)], refm[AW'(32'h44)]); end
        refm[AW'(32'h41)] = 8'hD4;
        refm[AW'(32'h42)] = 8'hC3;
        run_req(1'b0, SZ_B, 1'b1, 32'h42, 32'h0, o, e);
        checks++; if (o.rdata !== 32'hC3 || o.lat != 2) begin failures++; $display("FAIL rst_recover_lbu got %h lat %0d want c3 2", o.rdata, o.lat); end
`else
        run_req(1'b0, SZ_W, 1'b0, 32'h60, 32'h0, o, e);
        checks++; if (o.rdata !== e.rdata || o.lat != 2) begin failures++; $display("FAIL rst_recover_lw got %h lat %0d want %h 2", o.rdata, o.lat, e.rdata); end
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) refm[i] = 8'h00;
        rst_n = 1'b0; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_aligned();
        test_signed_bytes();
        test_misaligned();
        test_bounds_illegal();
        test_back_to_back();
        test_random();
        test_reset_split();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
